vm_coin_acceptor: RTL and testbench
===================================

Name: vm_coin_acceptor

Overview:
- Upstream money-input stage for vending_machine.
- Debounces three raw coin-sensor lines and queues recognised coins in a small FIFO.
- Presents queued coins one at a time to vending_machine as a mon value with an add_mon request, and waits for an acknowledge.
- Coins that cannot be delivered (rejected, timed out, or cancelled) are pulsed out on a refund path to the coin-return actuator.

Parameters:
- DEBOUNCE_CYC, 4, consecutive high samples required before a sensor line counts as a coin.
- FIFO_DEPTH, 4, coin queue entries; power of two, at least 2.
- ACK_TIMEOUT, 16, cycles add_mon may stay high without mon_ack before the coin is refunded.

Ports:
- clk  input  1  system clock, rising edge.
- res  input  1  reset, asynchronous, active-high.
- coin_in  input  [0:2]  raw sensor lines; [0]=1 unit, [1]=2 units, [2]=5 units.
- accept_en  input  1  vending_machine is in user money-accept state; delivery allowed.
- mon_ack  input  1  vending_machine has added the presented value to its balance.
- cancel  input  1  single-cycle request to refund every queued coin.
- mon  output  [0:2]  coin value presented to vending_machine.
- add_mon  output  1  mon is valid and is requesting to be added.
- refund  output  1  one-cycle pulse: eject one coin of value refund_val.
- refund_val  output  [0:2]  value of the coin being refunded.
- fifo_full  output  1  queue is full; new coins will be refunded.
- coin_cnt  output  [0:2]  number of entries currently queued.

Behaviour:
- Reset (asynchronous, active-high):
  - mon=0, add_mon=0, refund=0, refund_val=0, fifo_full=0, coin_cnt=0.
  - Debounce counters, FIFO pointers and FSM state all cleared; FSM enters IDLE.
  - A coin in flight at reset is lost. No refund is issued.
- Debounce, per sensor line:
  - Saturating counter increments while the line is high and clears when it is low.
  - A detect pulse fires once, in the cycle the counter reaches DEBOUNCE_CYC.
  - No further detect until the line has been low for at least one cycle.
- Coin classification, in the detect cycle:
  - Exactly one line detecting: value 1, 2 or 5.
  - Two or more lines detecting in the same cycle: refund=1 and refund_val=0 (unknown coin); nothing is queued.
- Enqueue:
  - Valid coin and FIFO not full: push the value.
  - Valid coin and FIFO full: refund the coin with refund_val equal to its value; FIFO unchanged.
- Refund port arbitration:
  - Only one refund pulse per cycle.
  - Priority: timeout refund > cancel drain > classification reject or full reject.
  - A lower-priority refund is held in a one-entry pending register and issued in the next free cycle.
  - If the pending register is already occupied, the new coin is queued instead if there is space.
- FSM states: IDLE, PRESENT, GAP, DRAIN.
  - IDLE: if cancel, go to DRAIN. Else if FIFO not empty and accept_en, drive mon from the FIFO head, set add_mon=1, clear the timeout counter, go to PRESENT.
  - PRESENT: add_mon stays 1 and mon stays stable.
    - mon_ack: pop the head, add_mon=0 next cycle, go to GAP.
    - accept_en drops (without mon_ack): add_mon=0, no pop, go to IDLE.
    - Timeout counter reaches ACK_TIMEOUT: refund the head, pop, go to GAP.
    - cancel: treated as accept_en dropping, then go to DRAIN.
    - If mon_ack and timeout occur in the same cycle, mon_ack wins (credit is delivered, no refund).
  - GAP: one cycle with add_mon=0, guaranteeing a low edge between requests. Then go to IDLE.
  - DRAIN: one refund per cycle of the FIFO head, popping each. Go to IDLE when empty. Coins detected during DRAIN are refunded, not queued.
- Simultaneous push and pop in one cycle: coin_cnt is unchanged and both operations take effect. Pointers wrap modulo FIFO_DEPTH.
- fifo_full = (coin_cnt == FIFO_DEPTH). coin_cnt is registered and updates in the cycle after a push or pop.
- Latency:
  - Sensor rising edge to detect: DEBOUNCE_CYC cycles.
  - Detect to FIFO entry: 1 cycle.
  - FIFO entry to add_mon: 1 cycle, from IDLE with accept_en high.

Decomposition:
- Shared package vm_pkg holds:
  - coin value constants COIN_1=3'd1, COIN_2=3'd2, COIN_5=3'd5, COIN_BAD=3'd0;
  - acceptor state encodings;
  - the vending_machine user-mode state number for accept_en decode.
- One sub-module: vm_coin_debounce, a single-line debouncer parameterised by DEBOUNCE_CYC, instantiated three times.
- The FIFO stays inline.

Test Plan:
1. Hold coin_in=3'b010 high for 6 cycles, accept_en=1, ack 2 cycles after add_mon. Expect add_mon=1 with mon=2 at cycle DEBOUNCE_CYC+2, then pop, GAP, and coin_cnt back to 0.
2. Glitch coin_in[0] high for 3 cycles (DEBOUNCE_CYC=4). Expect no detect, no refund, coin_cnt=0.
3. Insert 5 valid coins (1,2,5,1,2) with accept_en=0. Expect coin_cnt to reach 4 and fifo_full=1; the 5th coin gives refund=1, refund_val=2.
4. Queue one coin of 5, accept_en=1, never ack. Expect add_mon high for 16 cycles, then refund=1, refund_val=5, coin_cnt=0.
5. Queue coins 1,5, then pulse cancel in IDLE. Expect refunds with values 1 then 5 on consecutive cycles, and no add_mon.
6. Assert res mid-PRESENT with 2 coins queued. Expect add_mon=0 and coin_cnt=0 immediately, asynchronously, and no refund after reset is released.

Source files
------------

// File: rtl/vm_pkg.sv
// Shared definitions for the vending-machine money path: coin value codes,
// coin acceptor state encodings and the vending_machine state used to
// derive accept_en.
package vm_pkg;

    // Coin value codes as presented on mon / refund_val.
    localparam logic [2:0] COIN_BAD = 3'd0;
    localparam logic [2:0] COIN_1   = 3'd1;
    localparam logic [2:0] COIN_2   = 3'd2;
    localparam logic [2:0] COIN_5   = 3'd5;

    // Coin acceptor FSM states.
    typedef enum logic [1:0] {
        ACC_IDLE    = 2'd0,
        ACC_PRESENT = 2'd1,
        ACC_GAP     = 2'd2,
        ACC_DRAIN   = 2'd3
    } acc_state_e;

    // vending_machine state number of its user money-accept mode.
    localparam logic [2:0] VM_ST_USER = 3'd1;

    // accept_en as vending_machine derives it from its own state register.
    function automatic logic vm_accept_decode(input logic [2:0] vm_state);
        return vm_state == VM_ST_USER;
    endfunction

    // Map the three per-line detect pulses to a coin value. No detect and
    // more than one simultaneous detect both give COIN_BAD.
    function automatic logic [2:0] coin_classify(input logic [2:0] det);
        logic [2:0] val;
        case (det)
            3'b001:  val = COIN_1;
            3'b010:  val = COIN_2;
            3'b100:  val = COIN_5;
            default: val = COIN_BAD;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/vm_coin_debounce.sv
// Single-line coin sensor debouncer. A one-cycle detect pulse is issued when
// the line has been sampled high DEBOUNCE_CYC times in a row; another pulse
// needs the line to go low first. The line is expected to be synchronous
// to clk already.
module vm_coin_debounce #(
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic clk,
    input  logic res,
    input  logic line_i,
    output logic detect_o
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          detect_q, detect_d;

    // Saturating high-run counter; the detect is registered so it lines up
    // with the cycle in which the counter holds DEBOUNCE_CYC.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        cnt_d = cnt_q;
        if (!line_i) begin
            cnt_d = '0;
        end else if (cnt_q != CW'(DEBOUNCE_CYC)) begin
            cnt_d = cnt_q + CW'(1);
        end
        // Only the 'DEBOUNCE_CYC-1 -> DEBOUNCE_CYC' step fires, and the
        // counter cannot revisit that value until the line drops.
        detect_d = line_i && (cnt_q == CW'(DEBOUNCE_CYC - 1));
    end

    // Counter and detect registers.
    always_ff @(posedge clk or posedge res) begin
        // NOTE: state is updated with <= so every register samples the
        // pre-edge values regardless of statement order.
        if (res) begin
            cnt_q    <= '0;
            detect_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            detect_q <= detect_d;
        end
    end

    assign detect_o = detect_q;

endmodule

// File: rtl/vm_coin_acceptor.sv
// Coin acceptor: debounces three coin sensors, queues recognised coins and
// hands them one by one to vending_machine (mon/add_mon, mon_ack). Coins
// that cannot be credited leave through a single registered refund port.
module vm_coin_acceptor
    import vm_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int ACK_TIMEOUT  = 16
) (
    input  logic       clk,
    input  logic       res,
    input  logic [2:0] coin_in,
    input  logic       accept_en,
    input  logic       mon_ack,
    input  logic       cancel,
    output logic [2:0] mon,
    output logic       add_mon,
    output logic       refund,
    output logic [2:0] refund_val,
    output logic       fifo_full,
    output logic [2:0] coin_cnt
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);

    // Sensor front end.
    logic [2:0] det;
    logic [2:0] coin_val;
    logic       coin_valid;
    logic       coin_bad;

    // FSM, queue and refund state.
    acc_state_e       state_q, state_d;
    logic [2:0]       fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             pend_vld_q, pend_vld_d;
    logic [2:0]       pend_val_q, pend_val_d;
    logic             refund_q, refund_d;
    logic [2:0]       refund_val_q, refund_val_d;

    // Control derived each cycle.
    logic       fifo_empty;
    logic       full;
    logic [2:0] head;
    logic       timeout_hit;
    logic       pop;
    logic       push;
    logic       hi_ref;
    logic       new_rej;

    for (genvar g = 0; g < 3; g++) begin : g_deb
        vm_coin_debounce #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_deb (
            .clk      (clk),
            .res      (res),
            .line_i   (coin_in[g]),
            .detect_o (det[g])
        );
    end

    assign coin_val    = coin_classify(det);
    assign coin_valid  = (coin_val != COIN_BAD);
    assign coin_bad    = (det != 3'b000) && !coin_valid;

    assign fifo_empty  = (cnt_q == '0);
    assign full        = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign head        = fifo_mem_q[rd_ptr_q];
    assign timeout_hit = (state_q == ACC_PRESENT) &&
                         (to_cnt_q == TO_W'(ACK_TIMEOUT - 1));

    // FSM next state. In PRESENT an ack always wins; cancel and a dropped
    // accept_en both withdraw the request, leaving the coin queued.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ACC_IDLE: begin
                if (cancel) begin
                    state_d = ACC_DRAIN;
                end else if (!fifo_empty && accept_en) begin
                    state_d = ACC_PRESENT;
                end
            end
            ACC_PRESENT: begin
                if (mon_ack) begin
                    state_d = ACC_GAP;
                end else if (cancel) begin
                    state_d = ACC_DRAIN;
                end else if (!accept_en) begin
                    state_d = ACC_IDLE;
                end else if (timeout_hit) begin
                    state_d = ACC_GAP;
                end
            end
            ACC_GAP: begin
                state_d = ACC_IDLE;
            end
            ACC_DRAIN: begin
                if (fifo_empty) begin
                    state_d = ACC_IDLE;
                end
            end
            default: begin
                state_d = ACC_IDLE;
            end
        endcase
    end

    // FSM outputs: the request towards vending_machine, queue pops and the
    // high-priority refunds (timeout in PRESENT, one per cycle in DRAIN).
    always_comb begin
        add_mon = (state_q == ACC_PRESENT);
        mon     = add_mon ? head : COIN_BAD;
        pop     = 1'b0;
        hi_ref  = 1'b0;
        case (state_q)
            ACC_PRESENT: begin
                if (mon_ack) begin
                    pop = 1'b1;
                end else if (!cancel && accept_en && timeout_hit) begin
                    pop    = 1'b1;
                    hi_ref = 1'b1;
                end
            end
            ACC_DRAIN: begin
                if (!fifo_empty) begin
                    pop    = 1'b1;
                    hi_ref = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Enqueue and refund arbitration. The port carries at most one coin per
    // cycle: timeout/drain first, then the pending coin, then a fresh
    // reject. A reject that finds both port and pending slot busy is queued
    // if there is room, otherwise it is lost.
    always_comb begin
        new_rej      = coin_bad || (coin_valid && (full || state_q == ACC_DRAIN));
        push         = coin_valid && !full && (state_q != ACC_DRAIN);
        refund_d     = 1'b0;
        refund_val_d = COIN_BAD;
        pend_vld_d   = pend_vld_q;
        pend_val_d   = pend_val_q;
        if (hi_ref) begin
            refund_d     = 1'b1;
            refund_val_d = head;
            if (new_rej) begin
                if (!pend_vld_q) begin
                    pend_vld_d = 1'b1;
                    pend_val_d = coin_val;
                end else if (coin_valid && !full) begin
                    push = 1'b1;
                end
            end
        end else if (pend_vld_q) begin
            refund_d     = 1'b1;
            refund_val_d = pend_val_q;
            // The slot frees this cycle, so a fresh reject can take it.
            pend_vld_d   = new_rej;
            pend_val_d   = new_rej ? coin_val : pend_val_q;
        end else if (new_rej) begin
            refund_d     = 1'b1;
            refund_val_d = coin_val;
        end
    end

    // Queue pointers, occupancy and the ack timeout counter.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        // Runs only while presenting; any other state rearms it at zero.
        to_cnt_d = (state_q == ACC_PRESENT) ? to_cnt_q + TO_W'(1) : '0;
    end

    // Control state registers.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q      <= ACC_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            to_cnt_q     <= '0;
            pend_vld_q   <= 1'b0;
            pend_val_q   <= COIN_BAD;
            refund_q     <= 1'b0;
            refund_val_q <= COIN_BAD;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            to_cnt_q     <= to_cnt_d;
            pend_vld_q   <= pend_vld_d;
            pend_val_q   <= pend_val_d;
            refund_q     <= refund_d;
            refund_val_q <= refund_val_d;
        end
    end

    // Queue storage.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; an entry is only read after it has
        // been written, because occupancy and pointers are reset.
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= coin_val;
        end
    end

    assign refund     = refund_q;
    assign refund_val = refund_val_q;
    assign fifo_full  = full;
    assign coin_cnt   = 3'(cnt_q);

endmodule

// File: tb/tb_vm_coin_acceptor.sv
// Directed bench for vm_coin_acceptor with hand-computed expectations.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_vm_coin_acceptor;

    logic       clk;
    logic       res;
    logic [2:0] coin_in;
    logic       accept_en;
    logic       mon_ack;
    logic       cancel;
    logic [2:0] mon;
    logic       add_mon;
    logic       refund;
    logic [2:0] refund_val;
    logic       fifo_full;
    logic [2:0] coin_cnt;

    int n_total = 0;
    int n_bad   = 0;
    int n_ref   = 0;
    logic [2:0] last_ref_val = 3'd7;

    vm_coin_acceptor #(
        .DEBOUNCE_CYC (4),
        .FIFO_DEPTH   (4),
        .ACK_TIMEOUT  (16)
    ) dut (
        .clk        (clk),
        .res        (res),
        .coin_in    (coin_in),
        .accept_en  (accept_en),
        .mon_ack    (mon_ack),
        .cancel     (cancel),
        .mon        (mon),
        .add_mon    (add_mon),
        .refund     (refund),
        .refund_val (refund_val),
        .fifo_full  (fifo_full),
        .coin_cnt   (coin_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every refund pulse lasts one cycle, so one falling edge sees it once.
    always @(negedge clk) begin
        if (refund) begin
            n_ref        = n_ref + 1;
            last_ref_val = refund_val;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=no_finish exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        res       = 1'b1;
        coin_in   = 3'b000;
        accept_en = 1'b0;
        mon_ack   = 1'b0;
        cancel    = 1'b0;
        cyc(2);
        res = 1'b0;
        cyc(1);
    endtask

    // Coin sensor high for 5 cycles then low for 2; the push (or reject)
    // has landed by the time this returns.
    task automatic drop_coin(input logic [2:0] lines);
        coin_in = lines;
        cyc(5);
        coin_in = 3'b000;
        cyc(2);
    endtask

    initial begin
        int r0;
        int hi_cnt;
        int last_hi;
        int ref_idx;
        logic [2:0] ref_v;
        logic [2:0] first_mon;
        int rcnt;
        int add_seen;
        logic [2:0] rv [4];
        int ri [4];
        logic [2:0] t3_lines [5];
        int t3_cnt [5];

        res       = 1'b1;
        coin_in   = 3'b000;
        accept_en = 1'b0;
        mon_ack   = 1'b0;
        cancel    = 1'b0;
        cyc(2);

        // Reset state.
        check("rst_mon",        mon,        0);
        check("rst_add_mon",    add_mon,    0);
        check("rst_refund",     refund,     0);
        check("rst_refund_val", refund_val, 0);
        check("rst_fifo_full",  fifo_full,  0);
        check("rst_coin_cnt",   coin_cnt,   0);
        res = 1'b0;
        cyc(1);

        // 1: a 2-unit coin, presented DEBOUNCE_CYC+2 cycles after the
        // sensor rises, acked two cycles later.
        accept_en = 1'b1;
        coin_in   = 3'b010;
        cyc(5);
        check("t1_add_mon_c5",  add_mon,  0);
        check("t1_coin_cnt_c5", coin_cnt, 1);
        cyc(1);
        check("t1_add_mon_c6",  add_mon,  1);
        check("t1_mon_c6",      mon,      2);
        coin_in = 3'b000;
        cyc(1);
        check("t1_mon_c7",      mon,      2);
        cyc(1);
        check("t1_add_mon_c8",  add_mon,  1);
        mon_ack = 1'b1;
        cyc(1);
        mon_ack = 1'b0;
        check("t1_add_mon_gap", add_mon,  0);
        check("t1_coin_cnt_0",  coin_cnt, 0);
        cyc(3);
        check("t1_no_repeat",   add_mon,  0);
        check("t1_no_refund",   n_ref,    0);

        // 2: a 3-cycle glitch is not a coin.
        r0      = n_ref;
        coin_in = 3'b001;
        cyc(3);
        coin_in = 3'b000;
        cyc(6);
        check("t2_coin_cnt",    coin_cnt, 0);
        check("t2_no_refund",   n_ref,    r0);
        check("t2_no_add_mon",  add_mon,  0);

        // 2b: two lines detecting together is an unknown coin.
        r0 = n_ref;
        drop_coin(3'b011);
        check("t2b_refund_cnt", n_ref,        r0 + 1);
        check("t2b_refund_val", last_ref_val, 0);
        check("t2b_coin_cnt",   coin_cnt,     0);

        // 3: fill the queue with accept_en low; the fifth coin bounces.
        apply_reset();
        t3_lines = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
        t3_cnt   = '{1, 2, 3, 4, 4};
        r0 = n_ref;
        for (int i = 0; i < 5; i++) begin
            drop_coin(t3_lines[i]);
            check($sformatf("t3_coin_cnt_%0d", i), coin_cnt, t3_cnt[i]);
            check($sformatf("t3_fifo_full_%0d", i), fifo_full, (i >= 3) ? 1 : 0);
        end
        check("t3_refund_cnt",  n_ref,        r0 + 1);
        check("t3_refund_val",  last_ref_val, 2);
        check("t3_no_add_mon",  add_mon,      0);

        // 4: a 5-unit coin is never acked: 16 cycles of add_mon, then it
        // comes back on the refund port in the following cycle.
        apply_reset();
        drop_coin(3'b100);
        check("t4_coin_cnt_1", coin_cnt, 1);
        accept_en = 1'b1;
        hi_cnt    = 0;
        last_hi   = -1;
        ref_idx   = -1;
        ref_v     = 3'd7;
        first_mon = 3'd7;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            if (add_mon) begin
                if (hi_cnt == 0) first_mon = mon;
                hi_cnt++;
                last_hi = i;
            end
            if (refund && ref_idx < 0) begin
                ref_idx = i;
                ref_v   = refund_val;
            end
        end
        check("t4_first_mon",    first_mon, 5);
        check("t4_add_mon_len",  hi_cnt,    16);
        check("t4_refund_slot",  ref_idx,   last_hi + 1);
        check("t4_refund_val",   ref_v,     5);
        check("t4_coin_cnt_0",   coin_cnt,  0);

        // 5: cancel in IDLE drains 1 then 5 on consecutive cycles.
        apply_reset();
        drop_coin(3'b001);
        drop_coin(3'b100);
        check("t5_coin_cnt_2", coin_cnt, 2);
        cancel = 1'b1;
        cyc(1);
        cancel   = 1'b0;
        rcnt     = 0;
        add_seen = 0;
        for (int k = 0; k < 4; k++) begin
            rv[k] = 3'd7;
            ri[k] = -10;
        end
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            if (add_mon) add_seen++;
            if (refund && rcnt < 4) begin
                rv[rcnt] = refund_val;
                ri[rcnt] = i;
                rcnt++;
            end
        end
        check("t5_refund_cnt",  rcnt,     2);
        check("t5_refund_val0", rv[0],    1);
        check("t5_refund_val1", rv[1],    5);
        check("t5_back_to_back", ri[1],   ri[0] + 1);
        check("t5_no_add_mon",  add_seen, 0);
        check("t5_coin_cnt_0",  coin_cnt, 0);

        // 6: asynchronous reset in the middle of PRESENT with two coins.
        apply_reset();
        drop_coin(3'b001);
        drop_coin(3'b010);
        check("t6_coin_cnt_2", coin_cnt, 2);
        accept_en = 1'b1;
        cyc(2);
        check("t6_presenting", add_mon, 1);
        r0 = n_ref;
        #2;
        res = 1'b1;
        #1;
        check("t6_async_add_mon",   add_mon,   0);
        check("t6_async_coin_cnt",  coin_cnt,  0);
        check("t6_async_mon",       mon,       0);
        check("t6_async_fifo_full", fifo_full, 0);
        @(negedge clk);
        res = 1'b0;
        cyc(25);
        check("t6_no_refund",   n_ref,    r0);
        check("t6_no_add_mon",  add_mon,  0);
        check("t6_coin_cnt_0",  coin_cnt, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
